mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares the single main-memory port between two cache controllers (req0 = I-side, req1 = D-side).
// - Round-robin arbitration; grant held until access completes.
// - Sequences the fixed-latency memory access using an internal wait counter.
// - Returns a one-cycle ready pulse plus read data to the granted requester.
// PARAMETERS
// - AW       16  address width
// - DW       16  data width
// - MEM_LAT  4   memory access time in cycles; legal range >= 1
// PORTS
// - clk          in   1   single clock, rising edge
// - rst_n        in   1   synchronous reset, active-low
// - req0_strobe  in   1   req0 access request; held until req0_rdy
// - req0_rw      in   1   1 = write, 0 = read
// - req0_addr    in   AW  req0 address
// - req0_wdata   in   DW  req0 write data
// - req0_rdy     out  1   req0 access complete, one-cycle pulse
// - req0_rdata   out  DW  req0 read data, valid while req0_rdy = 1
// - req1_*       -    -   identical set for requester 1
// - mem_strobe   out  1   memory access in progress
// - mem_rw       out  1   1 = write, 0 = read
// - mem_addr     out  AW  memory address
// - mem_wdata    out  DW  memory write data
// - mem_rdata    in   DW  memory read data, valid in last ACCESS cycle
// BEHAVIOUR
// - Reset values: state = IDLE; mem_strobe = 0; mem_rw = 0; mem_addr = 0; mem_wdata = 0;
//   rdy = 0 on both requesters; rdata = 0 on both requesters; counter = 0; last_grant = 1.
//   Because last_grant resets to 1, req0 wins the first tie.
// - Reset mid-access aborts the access; mem_strobe is 0 in the cycle after rst_n is sampled low.
// - FSM states and transitions:
//   - IDLE
//     - No strobe: stay in IDLE.
//     - Exactly one strobe: grant that requester.
//     - Both strobes: grant the requester != last_grant.
//     - On grant: latch rw/addr/wdata into mem_* registers, set gnt, load counter = MEM_LAT-1,
//       go to ACCESS.
//   - ACCESS
//     - mem_strobe = 1; mem_rw/addr/wdata held stable for the whole state.
//     - counter != 0: decrement and stay.
//     - counter == 0: capture mem_rdata into the granted requester's rdata register
//       (read only; on a write the rdata register is unchanged), go to DONE.
//   - DONE
//     - mem_strobe = 0; rdy of the granted requester = 1 for exactly this cycle.
//     - last_grant <= gnt; go to IDLE.
// - Latency: request accepted in IDLE at cycle 0 -> ACCESS for cycles 1..MEM_LAT -> rdy at cycle MEM_LAT+1.
//   - Minimum spacing between accepted requests: MEM_LAT+2 cycles.
// - Requester protocol:
//   - Hold strobe and operands until rdy is sampled high.
//   - Deassert strobe at that same clock edge.
//   - A strobe still high in IDLE is treated as a new request.
// - Strobe is sampled only in IDLE. Dropping strobe during ACCESS does not abort the access;
//   rdy still pulses.
// - The non-granted requester's strobe is ignored until IDLE; its rdy stays 0.
// - rdata holds its last captured value until the next read completes for that requester.
// - Counter width is $clog2(MEM_LAT+1). MEM_LAT = 1 gives a single ACCESS cycle.
// - Outputs are registered; there is no combinational path from any strobe to any mem_* output.
// STRUCTURE
// - Package mem_arb_pkg contains:
//   - typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
//   - localparams RW_READ = 1'b0 and RW_WRITE = 1'b1.
// - Sub-module mem_wait_ctr (parameter MEM_LAT):
//   - Inputs: ld, dec.
//   - Output: zero flag.
//   - Instantiated once; provides the load-counter / counter-done handshake to the FSM.
// - The top level holds the FSM, grant/last_grant flops, operand registers and rdata registers.
// TESTING
// - Single read, MEM_LAT=4: req0 read addr 0x0010, memory returns 0xBEEF ->
//   mem_strobe high cycles 1-4, req0_rdy at cycle 5, req0_rdata = 0xBEEF.
// - Simultaneous strobes from reset: req0 write 0x0020=0x1111, req1 read 0x0030 ->
//   req0 served first; req1 granted in the IDLE cycle after req0_rdy.
// - Back-to-back contention, both strobes held continuously for 4 accesses ->
//   grant order 0,1,0,1; no rdy on the wrong requester.
// - req1 drops strobe mid-ACCESS -> access completes; req1_rdy still pulses once;
//   no second access issued.
// - rst_n low during ACCESS cycle 2 -> mem_strobe = 0 and state = IDLE next cycle;
//   no rdy pulse; req0 wins the next tie.
// - MEM_LAT=1 build: read -> exactly 1 mem_strobe cycle; rdy at cycle 2; rdata captured correctly.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and access-direction constants for the memory port arbiter
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;
endpackage

// File: rtl/mem_wait_ctr.sv
// mem_wait_ctr: down-counter timing the fixed memory latency, flags zero on the last access cycle
module mem_wait_ctr #(
   parameter int MEM_LAT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ld,
   input  logic dec,
   output logic zero
);
   localparam int CW = $clog2(MEM_LAT + 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk) begin
      if (!rst_n) cnt <= '0;
      else if (ld) cnt <= CW'(MEM_LAT - 1);
      else if (dec && cnt != '0) cnt <= cnt - 1'b1;
   end
   assign zero = (cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one fixed-latency memory port between two requesters
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int MEM_LAT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0_strobe,
   input  logic          req0_rw,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_wdata,
   output logic          req0_rdy,
   output logic [DW-1:0] req0_rdata,
   input  logic          req1_strobe,
   input  logic          req1_rw,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_wdata,
   output logic          req1_rdy,
   output logic [DW-1:0] req1_rdata,
   output logic          mem_strobe,
   output logic          mem_rw,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);
   arb_state_t state;
   logic gnt, last_grant, zero, any, pick;
   assign any  = req0_strobe | req1_strobe;
   // on a tie the requester that was not served last wins
   assign pick = (req0_strobe & req1_strobe) ? ~last_grant : req1_strobe;
   mem_wait_ctr #(.MEM_LAT(MEM_LAT)) u_ctr (
      .clk  (clk),
      .rst_n(rst_n),
      .ld   (state == IDLE && any),
      .dec  (state == ACCESS),
      .zero (zero)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         mem_strobe <= 1'b0;
         mem_rw     <= RW_READ;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         req0_rdy   <= 1'b0;
         req1_rdy   <= 1'b0;
         req0_rdata <= '0;
         req1_rdata <= '0;
         gnt        <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         req0_rdy <= 1'b0;
         req1_rdy <= 1'b0;
         case (state)
            IDLE: if (any) begin
               gnt        <= pick;
               mem_rw     <= pick ? req1_rw : req0_rw;
               mem_addr   <= pick ? req1_addr : req0_addr;
               mem_wdata  <= pick ? req1_wdata : req0_wdata;
               mem_strobe <= 1'b1;
               state      <= ACCESS;
            end
            ACCESS: if (zero) begin
               mem_strobe <= 1'b0;
               req0_rdy   <= ~gnt;
               req1_rdy   <= gnt;
               if (mem_rw == RW_READ && !gnt) req0_rdata <= mem_rdata;
               if (mem_rw == RW_READ && gnt) req1_rdata <= mem_rdata;
               state      <= DONE;
            end
            DONE: begin
               last_grant <= gnt;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: transaction-timeline model check plus directed arbitration scenarios
module tb_mem_port_arbiter;
   localparam int L = 4;
   logic clk = 1'b0, rst_n = 1'b0;
   logic req0_strobe, req0_rw, req0_rdy, req1_strobe, req1_rw, req1_rdy;
   logic [15:0] req0_addr, req0_wdata, req0_rdata, req1_addr, req1_wdata, req1_rdata;
   logic mem_strobe, mem_rw;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic b_strobe, b_rdy, b_mem_strobe, b_mem_rw, b1_rdy;
   logic [15:0] b_addr, b_rdata, b1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic [15:0] mem [256];
   int tests = 0, fails = 0;
   int e = 0;
   assign mem_rdata   = mem[mem_addr[7:0]];
   assign b_mem_rdata = mem[b_mem_addr[7:0]];
   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(L)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_strobe(req0_strobe), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req0_rdy(req0_rdy), .req0_rdata(req0_rdata),
      .req1_strobe(req1_strobe), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .req1_rdy(req1_rdy), .req1_rdata(req1_rdata),
      .mem_strobe(mem_strobe), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) dut_l1 (
      .clk(clk), .rst_n(rst_n),
      .req0_strobe(b_strobe), .req0_rw(1'b0), .req0_addr(b_addr), .req0_wdata(16'h0),
      .req0_rdy(b_rdy), .req0_rdata(b_rdata),
      .req1_strobe(1'b0), .req1_rw(1'b0), .req1_addr(16'h0), .req1_wdata(16'h0),
      .req1_rdy(b1_rdy), .req1_rdata(b1_rdata),
      .mem_strobe(b_mem_strobe), .mem_rw(b_mem_rw), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, e);
      end
   endtask

   // Timeline model: an accepted transaction at edge p owns the port for edges p..p+L-1,
   // pulses rdy after edge p+L, and the next one can be accepted at edge p+L+2.
   int p = -100, nf = 0;
   bit busy = 0, who = 0, last = 1, op_rw = 0;
   logic [15:0] op_a = 0, op_d = 0;
   logic [15:0] x_rd [2] = '{16'h0, 16'h0};
   bit x_strobe = 0, x_rdy0 = 0, x_rdy1 = 0;
   always @(posedge clk) begin
      e++;
      if (!rst_n) begin
         busy = 0; nf = e + 1; last = 1; op_rw = 0; op_a = 0; op_d = 0;
         x_rd[0] = 0; x_rd[1] = 0;
      end else if (e >= nf && (req0_strobe || req1_strobe)) begin
         who   = (req0_strobe && req1_strobe) ? !last : req1_strobe;
         last  = who;
         busy  = 1;
         p     = e;
         nf    = e + L + 2;
         op_rw = who ? req1_rw : req0_rw;
         op_a  = who ? req1_addr : req0_addr;
         op_d  = who ? req1_wdata : req0_wdata;
      end
      if (rst_n && busy && e == p + L && !op_rw) x_rd[who] = mem[op_a[7:0]];
      x_strobe = rst_n && busy && e >= p && e <= p + L - 1;
      x_rdy0   = rst_n && busy && e == p + L && !who;
      x_rdy1   = rst_n && busy && e == p + L && who;
   end

   always @(negedge clk) if (e > 0) begin
      chk("mem_strobe", mem_strobe, x_strobe);
      chk("mem_rw", mem_rw, op_rw);
      chk("mem_addr", mem_addr, op_a);
      chk("mem_wdata", mem_wdata, op_d);
      chk("req0_rdy", req0_rdy, x_rdy0);
      chk("req1_rdy", req1_rdy, x_rdy1);
      chk("req0_rdata", req0_rdata, x_rd[0]);
      chk("req1_rdata", req1_rdata, x_rd[1]);
   end

   int strobe_cnt = 0, rdy0_cnt = 0, rdy1_cnt = 0, b_strobe_cnt = 0;
   int order[$];
   always @(posedge clk) begin
      #2;
      if (mem_strobe) strobe_cnt++;
      if (b_mem_strobe) b_strobe_cnt++;
      if (req0_rdy) begin rdy0_cnt++; order.push_back(0); end
      if (req1_rdy) begin rdy1_cnt++; order.push_back(1); end
   end

   task automatic wait_rdy(input int r, input int limit, output int at);
      at = -1;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk);
         if (r == 0 ? req0_rdy : req1_rdy) begin at = e; break; end
      end
      if (at < 0) begin
         tests++; fails++;
         $display("FAIL wait_rdy%0d: no rdy within %0d cycles", r, limit);
      end
   endtask

   task automatic set0(input bit s, input bit rw, input logic [15:0] a, input logic [15:0] d);
      req0_strobe = s; req0_rw = rw; req0_addr = a; req0_wdata = d;
   endtask

   task automatic set1(input bit s, input bit rw, input logic [15:0] a, input logic [15:0] d);
      req1_strobe = s; req1_rw = rw; req1_addr = a; req1_wdata = d;
   endtask

   initial begin
      int e0, at;
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
      mem[8'h10] = 16'hBEEF;
      mem[8'h30] = 16'hC0DE;
      set0(0, 0, 0, 0); set1(0, 0, 0, 0);
      b_strobe = 0; b_addr = 0;
      repeat (3) @(negedge clk);
      chk("reset_strobe", mem_strobe, 0);
      chk("reset_rdata0", req0_rdata, 0);
      rst_n = 1;
      @(negedge clk);
      // single read
      strobe_cnt = 0; e0 = e;
      set0(1, 0, 16'h0010, 0);
      wait_rdy(0, 20, at);
      set0(0, 0, 0, 0);
      chk("t1_rdy_cycle", at - e0, 5);
      chk("t1_strobe_cycles", strobe_cnt, 4);
      chk("t1_rdata", req0_rdata, 16'hBEEF);
      repeat (2) @(negedge clk);
      // simultaneous strobes straight out of reset
      rst_n = 0;
      repeat (2) @(negedge clk);
      rst_n = 1; e0 = e;
      set0(1, 1, 16'h0020, 16'h1111);
      set1(1, 0, 16'h0030, 0);
      wait_rdy(0, 20, at);
      set0(0, 0, 0, 0);
      chk("t2_rdy0_cycle", at - e0, 5);
      chk("t2_write_keeps_rdata0", req0_rdata, 0);
      wait_rdy(1, 20, at);
      set1(0, 0, 0, 0);
      chk("t2_rdy1_cycle", at - e0, 11);
      chk("t2_rdata1", req1_rdata, 16'hC0DE);
      @(negedge clk);
      // continuous contention
      order.delete();
      set0(1, 0, 16'h0040, 0);
      set1(1, 0, 16'h0050, 0);
      for (int k = 0; k < 40 && order.size() < 4; k++) @(negedge clk);
      set0(0, 0, 0, 0); set1(0, 0, 0, 0);
      chk("t3_count", order.size(), 4);
      if (order.size() >= 4) begin
         chk("t3_order0", order[0], 0);
         chk("t3_order1", order[1], 1);
         chk("t3_order2", order[2], 0);
         chk("t3_order3", order[3], 1);
      end
      chk("t3_rdata1", req1_rdata, 16'h1050);
      @(negedge clk);
      // req1 abandons its strobe mid-access
      strobe_cnt = 0; rdy0_cnt = 0; rdy1_cnt = 0;
      set1(1, 0, 16'h0060, 0);
      repeat (2) @(negedge clk);
      set1(0, 0, 0, 0);
      repeat (12) @(negedge clk);
      chk("t4_rdy1_pulses", rdy1_cnt, 1);
      chk("t4_rdy0_pulses", rdy0_cnt, 0);
      chk("t4_strobe_cycles", strobe_cnt, 4);
      chk("t4_rdata1", req1_rdata, 16'h1060);
      // serve req0 so a tie would otherwise go to req1, then reset mid-access
      set0(1, 0, 16'h0011, 0);
      wait_rdy(0, 20, at);
      set0(0, 0, 0, 0);
      @(negedge clk);
      set1(1, 0, 16'h0070, 0);
      repeat (2) @(negedge clk);
      rst_n = 0;
      set1(0, 0, 0, 0);
      rdy0_cnt = 0; rdy1_cnt = 0;
      @(negedge clk);
      chk("t5_strobe_after_rst", mem_strobe, 0);
      rst_n = 1;
      repeat (8) @(negedge clk);
      chk("t5_no_rdy", rdy0_cnt + rdy1_cnt, 0);
      e0 = e;
      set0(1, 0, 16'h0080, 0);
      set1(1, 0, 16'h0090, 0);
      wait_rdy(0, 20, at);
      set0(0, 0, 0, 0);
      chk("t5_tie_to_req0", at - e0, 5);
      wait_rdy(1, 20, at);
      set1(0, 0, 0, 0);
      @(negedge clk);
      // single-cycle latency build
      b_strobe_cnt = 0; e0 = e; at = -1;
      b_strobe = 1; b_addr = 16'h0010;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (b_rdy) begin at = e; break; end
      end
      b_strobe = 0;
      chk("t6_rdy_cycle", at - e0, 2);
      chk("t6_strobe_cycles", b_strobe_cnt, 1);
      chk("t6_rdata", b_rdata, 16'hBEEF);
      chk("t6_no_rdy1", b1_rdy, 0);
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
